// File: rtl/uart_rx_core.sv
// UART receive core: 16x oversampled 8N1 deserialiser with RDR/RDRF holding
// register, framing-error and overrun status for the SCI register bank.
module uart_rx_core #(
  parameter int unsigned DIV = 27,
  parameter int unsigned OSR = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rxd,
  input  logic       rie,
  input  logic       rd_clr,
  output logic [7:0] rdr,
  output logic       rdrf,
  output logic       fe,
  output logic       orun,
  output logic       rx_busy,
  output logic       rx_irq
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] DivLast = 16'(DIV - 1);
  localparam logic [3:0]  SmpLast = 4'(OSR - 1);
  localparam logic [3:0]  SmpMid  = 4'(OSR / 2 - 1);

  state_t      state_q, state_d;
  logic        rx_meta_q, rxs_q, rxs_prev_q;
  logic [15:0] pcnt_q, pcnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [2:0]  smp_q, smp_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdr_q, rdr_d;
  logic        rdrf_q, rdrf_d;
  logic        fe_q, fe_d;
  logic        orun_q, orun_d;
  logic        tick, maj, frame_done, stop_ok;

  assign tick  = (state_q != IDLE) && (pcnt_q == DivLast);
  assign smp_d = tick ? {smp_q[1:0], rxs_q} : smp_q;
  // Majority includes the sample taken on the current tick.
  assign maj   = (smp_d[0] & smp_d[1]) | (smp_d[0] & smp_d[2]) | (smp_d[1] & smp_d[2]);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      scnt_q     <= '0;
      bcnt_q     <= '0;
      smp_q      <= '1;
      shift_q    <= '0;
      rdr_q      <= '0;
      rdrf_q     <= 1'b0;
      fe_q       <= 1'b0;
      orun_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      scnt_q     <= scnt_d;
      bcnt_q     <= bcnt_d;
      smp_q      <= smp_d;
      shift_q    <= shift_d;
      rdr_q      <= rdr_d;
      rdrf_q     <= rdrf_d;
      fe_q       <= fe_d;
      orun_q     <= orun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = (state_q == IDLE || tick) ? '0 : pcnt_q + 16'd1;
    scnt_d     = tick ? scnt_q + 4'd1 : scnt_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    frame_done = 1'b0;
    stop_ok    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
          scnt_d  = '0;
          pcnt_d  = '0;
        end
      end
      START: begin
        if (tick && scnt_q == SmpMid) begin
          if (maj) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            scnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      DATA: begin
        if (tick && scnt_q == SmpLast) begin
          shift_d = {maj, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (tick && scnt_q == SmpLast) begin
          frame_done = 1'b1;
          stop_ok    = maj;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A read in the completion cycle frees RDR, so the new byte loads instead of overrunning.
  always_comb begin
    rdr_d  = rdr_q;
    rdrf_d = rdrf_q;
    fe_d   = fe_q;
    orun_d = orun_q;
    if (rd_clr) begin
      rdrf_d = 1'b0;
      fe_d   = 1'b0;
      orun_d = 1'b0;
    end
    if (frame_done) begin
      if (!rdrf_q || rd_clr) begin
        rdr_d  = shift_q;
        rdrf_d = 1'b1;
        fe_d   = ~stop_ok;
      end else begin
        orun_d = 1'b1;
      end
    end
  end

  assign rdr     = rdr_q;
  assign rdrf    = rdrf_q;
  assign fe      = fe_q;
  assign orun    = orun_q;
  assign rx_busy = (state_q != IDLE);
  assign rx_irq  = rdrf_q & rie;

endmodule
